// File: rtl/brq_pkg.sv
// Shared execute-stage types: decoder M-extension op encoding and the
// iterative multiply/divide FSM states.
package brq_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MULT = 3'd1,
        MD_DIV  = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

endpackage

// File: rtl/brq_exu_md_iter.sv
// Iterative RV32M multiply/divide: 32 radix-2 steps on operand magnitudes,
// then one sign-fix cycle, then a one-cycle result pulse.
module brq_exu_md_iter
    import brq_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ITER_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  md_op_e          op_i,
    input  logic [1:0]      signed_mode_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned DW = 2 * XLEN;
    localparam int unsigned AW = XLEN + 1;

    md_state_e       state_q, state_d;
    md_op_e          op_q;
    logic            a_neg_q, b_neg_q;
    logic [XLEN-1:0] a_mag_q, b_mag_q;
    logic [XLEN-1:0] result_q;
    logic [DW-1:0]   acc_q;
    logic [ITER_W-1:0] cnt_q;
    logic            ready_q, valid_q;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    logic            a_neg_c, b_neg_c, is_mul_c, accept_c, div_zero_c;
    logic [XLEN-1:0] a_mag_c, b_mag_c;

    always_comb begin
        a_neg_c    = signed_mode_i[0] & op_a_i[XLEN-1];
        b_neg_c    = signed_mode_i[1] & op_b_i[XLEN-1];
        a_mag_c    = cond_neg(op_a_i, a_neg_c);
        b_mag_c    = cond_neg(op_b_i, b_neg_c);
        is_mul_c   = (op_i == MD_OP_MULL) || (op_i == MD_OP_MULH);
        div_zero_c = (op_b_i == '0);
        accept_c   = (state_q == MD_IDLE) && valid_i && !kill_i;
    end

    // Shared 33-bit adder: multiplicand add in MULT, divisor trial-subtract in DIV.
    logic            add_sub;
    logic [AW-1:0]   add_x, add_y, add_sum;
    logic [DW-1:0]   mult_next, div_next;

    always_comb begin
        add_sub   = (state_q == MD_DIV);
        add_x     = add_sub ? acc_q[DW-1:XLEN-1] : {1'b0, acc_q[DW-1:XLEN]};
        add_y     = add_sub ? {1'b0, b_mag_q} : {1'b0, a_mag_q};
        add_sum   = add_x + (add_sub ? ~add_y : add_y) + AW'(add_sub);
        mult_next = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[DW-1:1]};
        // Negative difference (bit XLEN set) restores: plain shift, quotient bit 0.
        div_next  = add_sum[XLEN] ? {acc_q[DW-2:0], 1'b0}
                                  : {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    logic [DW-1:0]   prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix, fix_result;

    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? (~acc_q + DW'(1)) : acc_q;
        quot_fix = cond_neg(acc_q[XLEN-1:0], a_neg_q ^ b_neg_q);
        rem_fix  = cond_neg(acc_q[DW-1:XLEN], a_neg_q);
        case (op_q)
            MD_OP_MULL: fix_result = prod_fix[XLEN-1:0];
            MD_OP_MULH: fix_result = prod_fix[DW-1:XLEN];
            MD_OP_DIV:  fix_result = quot_fix;
            default:    fix_result = rem_fix;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (accept_c) begin
                    if (is_mul_c)        state_d = MD_MULT;
                    else if (div_zero_c) state_d = MD_DONE;
                    else                 state_d = MD_DIV;
                end
            end
            MD_MULT, MD_DIV: begin
                if (kill_i)              state_d = MD_IDLE;
                else if (cnt_q == '0)    state_d = MD_FIX;
            end
            MD_FIX:  state_d = kill_i ? MD_IDLE : MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MD_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == MD_IDLE);
            valid_q <= (state_d == MD_DONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= MD_OP_MULL;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (accept_c) begin
                        op_q    <= op_i;
                        a_neg_q <= a_neg_c;
                        b_neg_q <= b_neg_c;
                        a_mag_q <= a_mag_c;
                        b_mag_q <= b_mag_c;
                        cnt_q   <= ITER_W'(XLEN - 1);
                        // Multiplier magnitude or dividend magnitude seeds the low half.
                        acc_q   <= {{XLEN{1'b0}}, is_mul_c ? b_mag_c : a_mag_c};
                        if (!is_mul_c && div_zero_c)
                            result_q <= (op_i == MD_OP_DIV) ? '1 : op_a_i;
                    end
                end
                MD_MULT: begin
                    acc_q <= mult_next;
                    if (cnt_q != '0) cnt_q <= cnt_q - ITER_W'(1);
                end
                MD_DIV: begin
                    acc_q <= div_next;
                    if (cnt_q != '0) cnt_q <= cnt_q - ITER_W'(1);
                end
                MD_FIX: begin
                    if (!kill_i) result_q <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q && !kill_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_brq_exu_md_iter.sv
// Scoreboard bench for the iterative multiply/divide unit: checks results,
// completion cycle, kill/reset abort and request hold behaviour.
module tb_brq_exu_md_iter;
    import brq_pkg::*;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    md_op_e      op_i;
    logic [1:0]  signed_mode_i;
    logic [31:0] op_a_i, op_b_i;
    logic        kill_i;
    logic        ready_o, valid_o;
    logic [31:0] result_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    brq_exu_md_iter dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .op_i         (op_i),
        .signed_mode_i(signed_mode_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .kill_i       (kill_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .result_o     (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference results from native arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] md_model(input md_op_e op, input logic [1:0] mode,
                                             input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = mode[0] ? longint'($signed(a)) : longint'({32'b0, a});
        sb = mode[1] ? longint'($signed(b)) : longint'({32'b0, b});
        p  = 64'(sa * sb);
        case (op)
            MD_OP_MULL: return p[31:0];
            MD_OP_MULH: return p[63:32];
            MD_OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (mode == 2'b11) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                    return 32'($signed(a) / $signed(b));
                end
                return a / b;
            end
            default: begin
                if (b == 32'd0) return a;
                if (mode == 2'b11) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                    return 32'($signed(a) % $signed(b));
                end
                return a % b;
            end
        endcase
    endfunction

    // Called at a negedge; returns at the following negedge with valid_i low.
    task automatic issue(input md_op_e op, input logic [1:0] mode, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input bit track,
                         output int n_acc);
        int guard = 0;
        while (!ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) chk("ready_timeout", 32'(ready_o), 32'd1);
        valid_i       = 1'b1;
        op_i          = op;
        signed_mode_i = mode;
        op_a_i        = a;
        op_b_i        = b;
        n_acc         = cyc;
        if (track)
            sb_q.push_back('{exp_res, cyc + ((op inside {MD_OP_DIV, MD_OP_REM} && b == 32'd0) ? 1 : 34)});
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_i && valid_o) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 32'(valid_o), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", result_o, mon_e.res);
                chk("latency", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    initial begin
        int n, n2, g;
        md_op_e      rop;
        logic [1:0]  rmode;
        logic [31:0] ra, rb;

        rst_i = 1'b1; valid_i = 1'b0; kill_i = 1'b0;
        op_i = MD_OP_MULL; signed_mode_i = 2'b00; op_a_i = '0; op_b_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // MULL with exact completion and ready timing.
        issue(MD_OP_MULL, 2'b11, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, n);
        wait_cyc(n + 34);
        chk("busy_at_done", 32'(ready_o), 32'd0);
        @(negedge clk);
        chk("ready_after_done", 32'(ready_o), 32'd1);

        issue(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, n);
        issue(MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, n);
        issue(MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, n);
        issue(MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, n);
        issue(MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, n);
        issue(MD_OP_DIV,  2'b00, 32'd100, 32'd7, 32'd14, 1'b1, n);
        issue(MD_OP_REM,  2'b00, 32'd100, 32'd7, 32'd2, 1'b1, n);
        issue(MD_OP_DIV,  2'b11, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1, n);
        issue(MD_OP_REM,  2'b11, 32'h1234, 32'd0, 32'h0000_1234, 1'b1, n);
        issue(MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, n);
        issue(MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, n);

        // Kill mid-divide, then a fresh MULL in the very next cycle.
        issue(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 32'd0, 1'b0, n);
        wait_cyc(n + 10);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        chk("kill_ready", 32'(ready_o), 32'd1);
        issue(MD_OP_MULL, 2'b00, 32'd1000, 32'd3000, 32'd3000000, 1'b1, n2);
        chk("kill_reissue_cyc", 32'(n2), 32'(n + 11));

        // Request with kill in IDLE must not be taken.
        wait_cyc(n2 + 36);
        valid_i = 1'b1; kill_i = 1'b1;
        op_i = MD_OP_DIV; signed_mode_i = 2'b00; op_a_i = 32'h55; op_b_i = 32'd0;
        @(negedge clk);
        valid_i = 1'b0; kill_i = 1'b0;
        chk("kill_idle_ready", 32'(ready_o), 32'd1);
        repeat (3) @(negedge clk);

        // Reset mid-multiply abandons the operation.
        issue(MD_OP_MULL, 2'b00, 32'd5, 32'd9, 32'd0, 1'b0, n);
        wait_cyc(n + 5);
        rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(ready_o), 32'd1);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_result", result_o, 32'd0);
        rst_i = 1'b0;
        repeat (40) @(negedge clk);

        // Request held while busy is taken only once the unit is ready again.
        issue(MD_OP_MULL, 2'b11, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, 1'b1, n);
        valid_i = 1'b1; op_i = MD_OP_DIV; signed_mode_i = 2'b00;
        op_a_i = 32'd1000; op_b_i = 32'd33;
        g = 0;
        while (!ready_o && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("hold_accept_cyc", 32'(cyc), 32'(n + 35));
        sb_q.push_back('{32'd30, cyc + 34});
        @(negedge clk);
        valid_i = 1'b0;

        // Random operations against the reference model.
        for (int i = 0; i < 8; i++) begin
            rop   = md_op_e'(2'($urandom_range(0, 3)));
            rmode = (rop inside {MD_OP_DIV, MD_OP_REM}) ? (($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00)
                                                        : 2'($urandom_range(0, 3));
            ra    = $urandom;
            rb    = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            issue(rop, rmode, ra, rb, md_model(rop, rmode, ra, rb), 1'b1, n);
        end

        g = 0;
        while (sb_q.size() > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/brq_exu_md_iter.md
Name: brq_exu_md_iter

Overview:
Iterative multiply/divide unit in the execute stage, directly downstream of the ID stage decoder that emits md_op_e operations. It accepts one RV32M operation at a time and produces MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU results. It uses a 32-cycle radix-2 shift-add / restoring-division datapath on operand magnitudes, followed by one sign-fix cycle. The result is written back through the EX result mux.

Parameters:
XLEN, 32, operand and result width (only 32 is supported).
ITER_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
valid_i  in  1  operation request from ID
op_i  in  2  md_op_e: MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM
signed_mode_i  in  2  bit0: op_a is signed; bit1: op_b is signed
op_a_i  in  32  rs1 value (multiplicand or dividend)
op_b_i  in  32  rs2 value (multiplier or divisor)
kill_i  in  1  flush; aborts any in-flight operation
ready_o  out  1  unit idle, can accept a request
valid_o  out  1  result valid, one-cycle pulse
result_o  out  32  result

Behaviour:
- Reset: state=MD_IDLE, ready_o=1, valid_o=0, result_o=0, counter=0, internal accumulators=0. Reset during an operation abandons it; no valid_o is produced.
- Accept: a request is taken when valid_i && ready_o && !kill_i (cycle N). Operands are latched. Signs are taken as a_neg = signed_mode_i[0] & op_a_i[31] and b_neg = signed_mode_i[1] & op_b_i[31]. Operand magnitudes are latched. ready_o drops in cycle N+1.
- States: MD_IDLE, MD_MULT, MD_DIV, MD_FIX, MD_DONE.
- IDLE -> MULT (MULL/MULH), DIV (DIV/REM with op_b != 0), or DONE (divide by zero).
- MULT: 32 iterations, counter 31->0. If the multiplier lsb is set, add the multiplicand magnitude into the upper half of a 64-bit accumulator, then shift right by 1. Leaves to FIX after counter==0.
- DIV: 32 iterations of restoring division. Shift the {rem,quot} 64-bit register left by 1 and trial-subtract the divisor magnitude on a 33-bit difference. If the difference is non-negative, set the quotient lsb and keep the difference. Leaves to FIX after counter==0.
- FIX (1 cycle):
  - Product negated (64-bit two's complement) if a_neg^b_neg.
  - Quotient negated if a_neg^b_neg.
  - Remainder negated if a_neg (remainder sign follows the dividend).
  - Selects MULL = product[31:0], MULH = product[63:32], DIV = quotient, REM = remainder.
- DONE: valid_o=1 for exactly one cycle, result_o holds the result. Next state is IDLE; ready_o=1 in the cycle after DONE.
- Latency: normal ops have valid_o in cycle N+34 (1 latch + 32 iterations + 1 fix), next accept possible at N+35. Divide by zero has valid_o at N+1.
- Divide by zero: DIV/DIVU returns 0xFFFFFFFF; REM/REMU returns op_a_i unchanged.
- Signed overflow (0x80000000 / -1) needs no special path: the magnitude path yields quotient 0x80000000 and remainder 0.
- signed_mode_i for DIV/REM is 2'b11 (signed) or 2'b00 (unsigned); other values are undefined and are not produced by the decoder.
- No backpressure: the consumer must capture the result on valid_o. result_o holds its value after DONE until the next FIX.
- kill_i: in any non-IDLE state, return to IDLE next cycle with no valid_o. Killing during DONE suppresses valid_o that cycle. In IDLE, kill_i blocks acceptance even when valid_i=1.
- valid_i while busy is ignored; ID must hold the request until ready_o.
- Counter wrap: the counter decrements only in MULT/DIV and is reloaded to 31 at accept. Leaving MULT/DIV happens only when counter==0; there is no wrap-around path.

Decomposition:
- brq_pkg gains typedef enum logic [2:0] md_state_e {MD_IDLE, MD_MULT, MD_DIV, MD_FIX, MD_DONE}.
- md_op_e is reused unchanged.
- No sub-module is needed. A 33-bit adder/subtractor is shared between MULT and DIV inside the block. The magnitude/negate logic is an internal function.

Test Plan:
- MULL, signed_mode=11: op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB at N+34, one-cycle valid_o, ready_o high at N+35.
- MULH: signed 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU (mode=01) 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed division: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. Unsigned: DIVU 100 / 7 -> 14; REMU -> 2.
- Divide by zero: DIV 0x1234 / 0 -> 0xFFFFFFFF at N+1; REM 0x1234 / 0 -> 0x1234. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- kill_i asserted at N+10 of a DIV -> no valid_o, ready_o=1 at N+11. A new MULL accepted at N+11 completes correctly at N+45. valid_i with kill_i in IDLE -> not accepted.
- rst_i asserted mid-MULT (N+5) -> valid_o, result_o and state cleared next cycle, ready_o=1. valid_i held while busy -> ignored; the second op is accepted only at N+35.
